fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end that sits directly upstream of `instruction_memory`. It owns the program counter, issues `rd_en`/`addr` requests, and accounts for the memory's one-cycle registered read latency. It buffers returned instructions with their PCs in a 3-entry queue and hands them to decode over a valid/ready handshake. Branch/jump redirects flush all wrong-path state.

## Interface
Parameters:
- `BUS_WIDTH`, 16: address/instruction width; must match `instruction_memory`.
- `RESET_PC`, 16'h0000: PC loaded at reset; bit 0 must be 0.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserts immediately, releases synchronously to `clk` at the top level.
- `fetch_en`  in  1  high permits new requests; low halts issue, in-flight data still retires.
- `imem_rd_en`  out  1  read strobe to `instruction_memory`.
- `imem_addr`  out  BUS_WIDTH  byte address of the request, always even.
- `imem_instruction`  in  BUS_WIDTH  memory data, valid the cycle after `imem_rd_en`.
- `redirect_valid`  in  1  one-cycle pulse: redirect PC, flush.
- `redirect_pc`  in  BUS_WIDTH  redirect target; bit 0 ignored (forced 0).
- `id_valid`  out  1  queue head holds a valid instruction.
- `id_ready`  in  1  decode accepts head this cycle.
- `id_instruction`  out  BUS_WIDTH  head instruction.
- `id_pc`  out  BUS_WIDTH  byte PC of head instruction.

## Operation
- State: `pc` register, `inflight` flag plus `inflight_pc`, 3-entry circular queue of {instruction, pc} with 2-bit read/write pointers and a 0..3 `count`.
- `imem_addr` = `pc`. `imem_rd_en` = `fetch_en` & !`redirect_valid` & (`count` + `inflight` < 3). It depends only on registers and these two inputs; there is no path from `id_ready`.
- Issue cycle: `pc` <= `pc` + 2, modulo 2^BUS_WIDTH (0xFFFE wraps to 0x0000). `inflight` <= 1. `inflight_pc` <= `pc`. A cycle with no issue clears `inflight`.
- Return cycle (`inflight` = 1, no redirect): push {`imem_instruction`, `inflight_pc`}. Occupancy cannot overflow because of the credit rule.
- Pop: on `id_valid` & `id_ready`, advance the read pointer. Push and pop in the same cycle leave `count` unchanged.
- `id_valid` = (`count` != 0). `id_instruction` and `id_pc` come from the head entry and are don't-care while `id_valid` = 0.
- Redirect (highest priority):
  - `pc` <= {`redirect_pc`[15:1], 0}. Queue flushed (`count` = 0, pointers = 0). `inflight` <= 0.
  - The data returning next cycle for a killed request is discarded.
  - No issue occurs in the redirect cycle.
  - A handshake completing in the redirect cycle counts as accepted by decode.
- `fetch_en` low: no issue. Queued and in-flight entries still drain normally. `pc` holds.
- Reset mid-operation: all state returns to reset values immediately, and in-flight data is discarded.

## Timing
- Reset values: `pc` = `RESET_PC`, `inflight` = 0, `count` = 0, `id_valid` = 0, `id_instruction` = 0, `id_pc` = 0. `imem_rd_en` is forced 0 while `rst` is low. `imem_addr` = `RESET_PC`.
- Reset release at cycle 0 with `fetch_en` = 1:
  - request PC0 issued at cycle 0;
  - memory data at cycle 1;
  - `id_valid` at cycle 2.
- Issue-to-`id_valid` latency is 2 cycles.
- Throughput is 1 instruction/cycle sustained while `id_ready` = 1. Steady state is `count` = 1 and `inflight` = 1.
- Redirect at cycle N: request to the target at N+1; target instruction presented at N+3. `id_valid` = 0 during N+1 and N+2.
- Decode stall: issue stops once `count` + `inflight` = 3. Resumes the cycle after the pop that drops occupancy.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds two outputs, both reset to 0 and saturating at 0xFFFF:
  - `perf_fetched` (16 bits): increments on each `id_valid` & `id_ready`.
  - `perf_bubbles` (16 bits): increments each cycle with `id_ready` = 1 and `id_valid` = 0.
- Undefined: both ports and their counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, `fetch_en` = 1, `id_ready` = 1, memory preloaded word k = 0x1000 + k -> `id_valid` from cycle 2; `id_pc` = 0, 2, 4, … with `id_instruction` = 0x1000, 0x1001, … every cycle, no gaps.
- `id_ready` held low for 6 cycles from reset -> exactly 3 issues (`count` = 3, `imem_rd_en` = 0). Release -> PCs 0, 2, 4, 6 delivered in order with no loss or duplication.
- `redirect_valid` with `redirect_pc` = 0x0041 while an entry is in flight and the queue holds 2 -> flush. Next issue address is 0x0040; first delivered `id_pc` = 0x0040, 3 cycles after redirect.
- `RESET_PC` = 0xFFFC, free-running -> `id_pc` sequence 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- `fetch_en` dropped mid-stream, then `rst` pulsed low mid-stream -> in-flight word still delivered after `fetch_en` drops. Reset pulse forces all outputs to reset values asynchronously; fetch restarts at `RESET_PC`.
- With `FETCH_PERF_CNT_EN`: 10 accepted instructions plus a 2-cycle initial bubble -> `perf_fetched` = 10, `perf_bubbles` = 2.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues reads to instruction_memory,
// buffers {instruction, pc} in a 3-entry queue for decode. Optional macro: FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter int unsigned          BUS_WIDTH = 16,
   parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_en,
   output logic                 imem_rd_en,
   output logic [BUS_WIDTH-1:0] imem_addr,
   input  logic [BUS_WIDTH-1:0] imem_instruction,
   input  logic                 redirect_valid,
   input  logic [BUS_WIDTH-1:0] redirect_pc,
   output logic                 id_valid,
   input  logic                 id_ready,
   output logic [BUS_WIDTH-1:0] id_instruction,
   output logic [BUS_WIDTH-1:0] id_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]          perf_fetched,
   output logic [15:0]          perf_bubbles
`endif
);

   logic [BUS_WIDTH-1:0] r_pc;
   logic                 r_inflight;
   logic [BUS_WIDTH-1:0] r_inflight_pc;
   logic [BUS_WIDTH-1:0] r_q_instr [3];
   logic [BUS_WIDTH-1:0] r_q_pc    [3];
   logic [1:0]           r_rd_ptr;
   logic [1:0]           r_wr_ptr;
   logic [1:0]           r_count;

   logic w_valid;
   logic w_issue;
   logic w_push;
   logic w_pop;

   function automatic logic [1:0] f_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Credit rule: queued entries plus the outstanding read never exceed the queue depth.
   assign w_issue = rst & fetch_en & ~redirect_valid &
                    (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3);
   assign w_push  = r_inflight & ~redirect_valid;
   assign w_valid = (r_count != 2'd0);
   assign w_pop   = w_valid & id_ready;

   assign imem_rd_en     = w_issue;
   assign imem_addr      = r_pc;
   assign id_valid       = w_valid;
   assign id_instruction = w_valid ? r_q_instr[r_rd_ptr] : '0;
   assign id_pc          = w_valid ? r_q_pc[r_rd_ptr]    : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_q_instr     <= '{default: '0};
         r_q_pc        <= '{default: '0};
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[BUS_WIDTH-1:1], 1'b0};
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc          <= r_pc + BUS_WIDTH'(2);
            r_inflight_pc <= r_pc;
         end
         if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_instruction;
            r_q_pc[r_wr_ptr]    <= r_inflight_pc;
            r_wr_ptr            <= f_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_perf_fetched;
   logic [15:0] r_perf_bubbles;

   // A handshake in a redirect cycle still counts as delivered to decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_fetched <= '0;
         r_perf_bubbles <= '0;
      end else begin
         if (w_pop && (r_perf_fetched != 16'hFFFF)) begin
            r_perf_fetched <= r_perf_fetched + 16'd1;
         end
         if (id_ready && !w_valid && (r_perf_bubbles != 16'hFFFF)) begin
            r_perf_bubbles <= r_perf_bubbles + 16'd1;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
